// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: program memory, program counter and a registered
// instruction slot feeding the control unit. Supports loading while idle or
// halted, back-pressure from the control unit, branch redirect with flush, and
// stop on the HALT opcode.
module instr_fetch_unit #(
  parameter int         ADDR_W  = 8,
  parameter int         DEPTH   = 256,
  parameter int         INSTR_W = 32,
  parameter logic [3:0] HALT_OP = 4'hF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic               start,
  input  logic               cu_ready,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic [INSTR_W-1:0] instruction,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [ADDR_W-1:0]    pc_out_q, pc_out_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 valid_q, valid_d;
  logic                 halted_q, halted_d;

  // Program memory is deliberately left out of reset so a reset keeps the program.
  logic [INSTR_W-1:0]   mem_q [DEPTH];
  logic [INSTR_W-1:0]   fetch_word;
  logic                 mem_we;
  logic                 fetch_is_halt;

  // Loading is only allowed when not actively fetching.
  assign mem_we        = prog_we && (state_q != S_FETCH);
  assign fetch_word    = mem_q[pc_q];
  assign fetch_is_halt = (fetch_word[INSTR_W-1 -: 4] == HALT_OP);

  // Program memory write port.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Next-state logic: branch beats stall, stall beats fetch.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    pc_out_d = pc_out_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    halted_d = halted_q;
    case (state_q)
      S_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        valid_d  = 1'b0;
        halted_d = 1'b1;
        if (start) begin
          halted_d = 1'b0;
          pc_d     = '0;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        if (branch_taken) begin
          // Flush the slot; the redirected word is fetched on the next edge.
          pc_d    = branch_target;
          valid_d = 1'b0;
        end else if (valid_q && !cu_ready) begin
          // Stall: everything holds.
          pc_d    = pc_q;
        end else if (fetch_is_halt) begin
          // The HALT word is never issued and pc stays on it.
          state_d  = S_HALT;
          halted_d = 1'b1;
          valid_d  = 1'b0;
        end else begin
          instr_d  = fetch_word;
          pc_out_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d  = S_IDLE;
        valid_d  = 1'b0;
        halted_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      pc_out_q <= '0;
      instr_q  <= '0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      pc_out_q <= pc_out_d;
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign instruction = instr_q;
  assign instr_valid = valid_q;
  assign pc_out      = pc_out_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a per-cycle vector table plus hand-written
// sequences; every word the control unit accepts is checked against a queue
// of expected {word, pc} pairs.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        prog_we;
  logic [7:0]  prog_addr;
  logic [31:0] prog_data;
  logic        start;
  logic        cu_ready;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;

  instr_fetch_unit #(
    .ADDR_W (8),
    .DEPTH  (256),
    .INSTR_W(32),
    .HALT_OP(4'hF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .start        (start),
    .cu_ready     (cu_ready),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc_out       (pc_out),
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          st;
    bit          cu;
    bit          br;
    logic [7:0]  tgt;
    bit          ev;
    bit          eh;
    bit          push;
    logic [7:0]  epc;
    logic [31:0] ewd;
  } vec_t;

  typedef struct {
    logic [31:0] w;
    logic [7:0]  p;
  } sb_t;

  vec_t tbl [32];
  sb_t  sb_q [$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(bit st, bit cu, bit br, logic [7:0] tgt, bit ev, bit eh,
                              bit push, logic [7:0] epc, logic [31:0] ewd);
    vec_t v;
    v.st = st; v.cu = cu; v.br = br; v.tgt = tgt; v.ev = ev; v.eh = eh;
    v.push = push; v.epc = epc; v.ewd = ewd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock; called at posedge+1, returns at the next posedge+1.
  // A word is accepted when valid and cu_ready are both high at the edge.
  task automatic tick();
    logic        acc;
    logic [31:0] w;
    logic [7:0]  p;
    sb_t         e;
    #3;
    acc = rst_n && instr_valid && cu_ready;
    w   = instruction;
    p   = pc_out;
    @(posedge clk);
    #1;
    if (acc) begin
      if (sb_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_extra: got %h at pc %h expected no accepted word", w, p);
      end else begin
        e = sb_q.pop_front();
        chk("sb_word", w, e.w);
        chk("sb_pc", {24'h0, p}, {24'h0, e.p});
      end
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [31:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic load_prog1();
    load(8'h00, 32'h1000_0001);
    load(8'h01, 32'h2000_0002);
    load(8'h02, 32'h3000_0003);
    load(8'h03, 32'hF000_0000);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    vec_t v;
    for (int i = lo; i <= hi; i++) begin
      v = tbl[i];
      start         = v.st;
      cu_ready      = v.cu;
      branch_taken  = v.br;
      branch_target = v.tgt;
      if (v.push) sb_q.push_back('{v.ewd, v.epc});
      tick();
      chk($sformatf("v%0d_valid", i), {31'h0, instr_valid}, {31'h0, v.ev});
      chk($sformatf("v%0d_halted", i), {31'h0, halted}, {31'h0, v.eh});
      if (v.ev) begin
        chk($sformatf("v%0d_word", i), instruction, v.ewd);
        chk($sformatf("v%0d_pc", i), {24'h0, pc_out}, {24'h0, v.epc});
      end
    end
    start        = 1'b0;
    branch_taken = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    //            st cu br tgt    ev eh push epc    ewd
    tbl[0]  = mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    tbl[1]  = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 32'h1000_0001);
    tbl[2]  = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h01, 32'h2000_0002);
    tbl[3]  = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h02, 32'h3000_0003);
    tbl[4]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);
    tbl[5]  = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);
    tbl[6]  = mk(1, 0, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    tbl[7]  = mk(0, 0, 0, 8'h00, 1, 0, 1, 8'h00, 32'h1000_0001);
    tbl[8]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h1000_0001);
    tbl[9]  = mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h1000_0001);
    tbl[10] = mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h1000_0001);
    tbl[11] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h01, 32'h2000_0002);
    tbl[12] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h02, 32'h3000_0003);
    tbl[13] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);
    tbl[14] = mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    tbl[15] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 32'h0100_0000);
    tbl[16] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h01, 32'h0100_0001);
    tbl[17] = mk(0, 1, 1, 8'h40, 0, 0, 0, 8'h00, 32'h0);
    tbl[18] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h40, 32'h5000_0040);
    tbl[19] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h41, 32'h0200_0041);
    tbl[20] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);
    tbl[21] = mk(1, 1, 0, 8'h00, 0, 0, 0, 8'h00, 32'h0);
    tbl[22] = mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 32'h2222_2222);
    tbl[23] = mk(0, 0, 1, 8'hFF, 0, 0, 0, 8'h00, 32'h0);
    tbl[24] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'hFF, 32'h1111_1111);
    tbl[25] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 32'h2222_2222);
    tbl[26] = mk(0, 1, 1, 8'hFF, 0, 0, 0, 8'h00, 32'h0);
    tbl[27] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'hFF, 32'h1111_1111);
    tbl[28] = mk(0, 1, 0, 8'h00, 1, 0, 1, 8'h00, 32'h2222_2222);
    tbl[29] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);
    tbl[30] = mk(0, 0, 1, 8'h40, 0, 1, 0, 8'h00, 32'h0);
    tbl[31] = mk(0, 1, 0, 8'h00, 0, 1, 0, 8'h00, 32'h0);

    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
    start = 1'b0; cu_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
    @(posedge clk);
    #1;
    chk("rst_instr", instruction, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_pc_out", {24'h0, pc_out}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Straight-line run to HALT, then a stalled rerun.
    load_prog1();
    run_vecs(0, 5);
    chk("halt_pc", {24'h0, dut.pc_q}, 32'h3);
    run_vecs(6, 13);

    // Branch redirect.
    for (int i = 0; i < 6; i++) load(8'(i), 32'h0100_0000 + 32'(i));
    load(8'h40, 32'h5000_0040);
    load(8'h41, 32'h0200_0041);
    load(8'h42, 32'hF000_0000);
    run_vecs(14, 20);

    // Wrap-around, branch while stalled, branch over a HALT word, branch in HALT.
    load(8'hFF, 32'h1111_1111);
    load(8'h00, 32'h2222_2222);
    load(8'h01, 32'hF000_0000);
    run_vecs(21, 31);

    // Writes attempted during FETCH must not reach memory.
    load_prog1();
    cu_ready = 1'b1;
    start = 1'b1;
    sb_q.push_back('{32'h1000_0001, 8'h00});
    sb_q.push_back('{32'h2000_0002, 8'h01});
    sb_q.push_back('{32'h3000_0003, 8'h02});
    tick();
    start = 1'b0;
    prog_we = 1'b1; prog_addr = 8'h02; prog_data = 32'hDEAD_BEEF;
    tick();
    tick();
    tick();
    chk("fetchwr_word", instruction, 32'h3000_0003);
    chk("fetchwr_pc", {24'h0, pc_out}, 32'h2);
    prog_we = 1'b0;
    tick();
    chk("fetchwr_halted", {31'h0, halted}, 32'h1);
    chk("fetchwr_mem2", dut.mem_q[2], 32'h3000_0003);

    // Asynchronous reset in the middle of a fetch stream.
    start = 1'b1;
    sb_q.push_back('{32'h1000_0001, 8'h00});
    sb_q.push_back('{32'h2000_0002, 8'h01});
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_rst_word", instruction, 32'h2000_0002);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_instr", instruction, 32'h0);
    chk("arst_valid", {31'h0, instr_valid}, 32'h0);
    chk("arst_pc_out", {24'h0, pc_out}, 32'h0);
    chk("arst_halted", {31'h0, halted}, 32'h0);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk("post_rst_valid", {31'h0, instr_valid}, 32'h0);
    start = 1'b1;
    sb_q.push_back('{32'h1000_0001, 8'h00});
    sb_q.push_back('{32'h2000_0002, 8'h01});
    sb_q.push_back('{32'h3000_0003, 8'h02});
    tick();
    start = 1'b0;
    chk("restart_lat_valid", {31'h0, instr_valid}, 32'h0);
    tick();
    chk("restart_word", instruction, 32'h1000_0001);
    chk("restart_pc", {24'h0, pc_out}, 32'h0);
    tick();
    tick();
    tick();
    chk("restart_halted", {31'h0, halted}, 32'h1);

    chk("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
